// File: rtl/tytra_stream_pkg.sv
// rtl/tytra_stream_pkg.sv - shared defaults and helpers for tytra stream balance buffers
package tytra_stream_pkg;

   localparam int STREAMW_DEF = 32;
   localparam int DEPTH_DEF   = 4;

   // Pointer width for a FIFO of the given depth; kernel tops use the same rule.
   function automatic int aw_of(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

   // LSB of channel c inside a packed multi-channel word.
   function automatic int chan_lsb(input int c, input int streamw);
      return c * streamw;
   endfunction

endpackage

// File: rtl/tytra_sync_fifo_fwft.sv
// rtl/tytra_sync_fifo_fwft.sv - single-stream first-word-fall-through FIFO with occupancy
module tytra_sync_fifo_fwft
   import tytra_stream_pkg::*;
#(
   parameter int W     = STREAMW_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = aw_of(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  logic [W-1:0]  i_data,
   input  logic          i_pop,
   output logic [W-1:0]  o_data,
   output logic [AW:0]   o_count,
   output logic          o_full,
   output logic          o_empty
);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_push;
   logic          w_pop;

   // Guard here as well so a full FIFO never accepts, whatever the caller does.
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_data  = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/tytra_stream_balance_buffer.sv
// rtl/tytra_stream_balance_buffer.sv - multi-channel join plus elastic FWFT path-balancing buffer
module tytra_stream_balance_buffer
   import tytra_stream_pkg::*;
#(
   parameter int STREAMW = STREAMW_DEF,
   parameter int NCH     = 2,
   parameter int DEPTH   = DEPTH_DEF,
   parameter int AW      = aw_of(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NCH-1:0]         ivalid,
   output logic                   iready,
   input  logic [NCH*STREAMW-1:0] in,
   output logic                   ovalid,
   input  logic                   oready,
   output logic [NCH*STREAMW-1:0] out,
   output logic [AW:0]            count,
   output logic                   full,
   output logic                   empty,
   output logic                   skew_err
);

   logic [NCH*STREAMW-1:0] w_join;
   logic [NCH*STREAMW-1:0] w_head;
   logic                   w_full;
   logic                   w_empty;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_partial;
   logic                   r_skew_arm;
   logic                   r_skew_err;

   for (genvar c = 0; c < NCH; c++) begin : g_chan
      assign w_join[chan_lsb(c, STREAMW) +: STREAMW] = in[chan_lsb(c, STREAMW) +: STREAMW];
      assign out[chan_lsb(c, STREAMW) +: STREAMW]    = w_head[chan_lsb(c, STREAMW) +: STREAMW];
   end

   // Ready comes only from registered occupancy, so there is no oready->iready path.
   assign iready    = ~w_full;
   assign ovalid    = ~w_empty;
   assign full      = w_full;
   assign empty     = w_empty;
   assign w_push    = (&ivalid) & ~w_full;
   assign w_pop     = oready & ~w_empty;
   assign w_partial = (|ivalid) & ~(&ivalid);
   assign skew_err  = r_skew_err;

   tytra_sync_fifo_fwft #(
      .W     (NCH*STREAMW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (w_join),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_count (count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // A single skewed cycle is normal arrival jitter; two in a row is flagged.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_skew_arm <= 1'b0;
         r_skew_err <= 1'b0;
      end else begin
         r_skew_arm <= w_partial & iready;
         if (w_partial & iready & r_skew_arm) begin
            r_skew_err <= 1'b1;
         end
      end
   end

endmodule

// File: doc/tytra_stream_balance_buffer.md
Name: tytra_stream_balance_buffer

Overview:
- Parametrised multi-channel path-balancing buffer for hierarchical map-node kernel tops. Generalises the fixed single-stream delay buffer placed on a short operand path so it lines up with a longer compute path (e.g. y alongside mul->div).
- Joins NCH input streams into one valid/ready transaction.
- Stores up to DEPTH joined words in an elastic FIFO and presents them first-word-fall-through to the consumer.
- Provides occupancy/status so the generator can size DEPTH to the compute-path latency.

Parameters:
- STREAMW, 32, width of each channel word.
- NCH, 2, number of joined channels (>=1).
- DEPTH, 4, FIFO entries (power of 2, >=2).
- AW, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- ivalid  input  NCH  per-channel input valid
- iready  output  1  shared input ready to all channels
- in  input  NCH*STREAMW  channel c at bits [c*STREAMW +: STREAMW]
- ovalid  output  1  head word valid
- oready  input  1  consumer ready
- out  output  NCH*STREAMW  head word, same channel packing as in
- count  output  AW+1  occupancy 0..DEPTH
- full  output  1  count==DEPTH
- empty  output  1  count==0
- skew_err  output  1  sticky: some but not all ivalid high while iready high

Behaviour:
- One clock (clk); reset synchronous, active-high (rst). Reset has priority over every other event in the same cycle.
- Reset values: wr_ptr=rd_ptr=0, count=0, empty=1, full=0, ovalid=0, iready=1 (combinational from full), out=0 (all storage entries cleared), skew_err=0.
- Join rule: push = (&ivalid) & iready. No partial pushes; channels with early ivalid hold their data until all channels are valid.
- iready = ~full. Depends only on registered state, never on oready, so there is no combinational ready path through the block. A push into a full buffer is never accepted, even if a pop occurs in the same cycle.
- pop = ovalid & oready. ovalid = ~empty. out = mem[rd_ptr], combinationally from registered pointer and storage (first-word-fall-through).
- Latency: a word pushed at edge k is on out with ovalid=1 in the cycle after edge k (1-cycle latency when empty). Throughput is 1 word/cycle sustained when 0<count<DEPTH.
- Push only: mem[wr_ptr]<=in, wr_ptr+1, count+1.
- Pop only: rd_ptr+1, count-1.
- Push and pop together (only possible when not empty and not full): both pointers advance and count is unchanged.
- Pointers wrap modulo DEPTH (natural AW-bit wrap). count is kept separately, AW+1 bits.
- out is stable while ovalid=1 and oready=0.
- Pop when empty cannot occur (ovalid=0).
- skew_err: set when iready=1 and ivalid is neither all-0 nor all-1 for 2+ consecutive cycles. Single-cycle skew is legal. Cleared only by rst. Debug aid only; it does not affect dataflow.
- Reset mid-operation discards all stored words. The consumer sees ovalid drop in the cycle after the rst edge.
- NCH=1: the join degenerates to a plain FIFO and skew_err stays 0.

Decomposition:
- Shared package tytra_stream_pkg holds:
  - the channel-slice helper function (c*STREAMW +: STREAMW);
  - localparam defaults STREAMW_DEF=32 and DEPTH_DEF=4;
  - the $clog2-based AW derivation, so kernel tops and this block agree.
- One natural sub-module, tytra_sync_fifo_fwft: single-stream FIFO with storage, pointers, count, full/empty, instantiated once at width NCH*STREAMW. The top holds the join logic, the skew detector and the port packing.

Test Plan:
- Reset then idle: assert rst 1 cycle, hold ivalid=0 -> iready=1, ovalid=0, count=0, empty=1, out=0, skew_err=0.
- Fill and drain, NCH=2, DEPTH=4, oready=0:
  - Push pairs (1,10),(2,20),(3,30),(4,40) -> count 1..4, full=1, iready=0.
  - A 5th pair (5,50) is held off (not accepted).
  - Raise oready -> out yields (1,10)..(4,40) on consecutive cycles, then empty=1.
- Streaming: ivalid=2'b11 and oready=1 every cycle, inputs 0..99 -> out sequence 0..99 with 1-cycle latency, count steady at 1, no bubbles.
- Full with simultaneous pop: count=4, ivalid=11, oready=1 -> pop only, count=3; push accepted the following cycle.
- Skew:
  - ivalid=01 for 1 cycle then 11 -> one push, skew_err=0.
  - ivalid=10 held 3 cycles -> no push, skew_err=1 and stays 1 until rst.
- Reset mid-operation: count=3, assert rst alongside a push and a pop -> next cycle count=0, ovalid=0, out=0; subsequent push of (7,70) appears next cycle.
